if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit feeding the `id` decode stage. Holds the PC, issues in-order word fetches to instruction memory over a request/grant + response-valid interface, buffers returned words in a small FIFO, and presents `inst_o`/`inst_addr_o` to decode with a valid/ready handshake. A jump redirect from execute flushes the buffer and discards in-flight responses.

## Interface

- `RESET_PC`, 32'h8000_0000, PC loaded on reset
- `DEPTH`, 2, instruction buffer entries; power of two, 2..8; also caps total in-flight fetches
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `jump_en_i`  in  1  redirect request from execute
- `jump_addr_i`  in  32  redirect target, word-aligned
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  32  fetch address
- `imem_gnt_i`  in  1  request accepted this cycle
- `imem_rvalid_i`  in  1  response valid; in order, at least 1 cycle after its grant
- `imem_rdata_i`  in  32  response instruction word
- `inst_valid_o`  out  1  buffer head valid
- `inst_o`  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- `inst_addr_o`  out  32  head instruction address; 0 when empty
- `inst_ready_i`  in  1  decode accepts head

## Operation

- State: `pc` (next fetch address), `rsp_pc` (address of next non-discarded response), `inflight` (granted, response not yet returned, incl. discards; 0..DEPTH), `discard` (responses to drop; ≤ inflight), FIFO of {word, addr}, `occ` (0..DEPTH).
- `pop` = `inst_valid_o & inst_ready_i`.
- `imem_req_o` = !rst & !jump_en_i & (inflight + occ − pop < DEPTH). `imem_addr_o` = `pc`.
- Grant (`imem_req_o & imem_gnt_i`): `pc` += 4 (mod 2^32 wrap), `inflight` += 1.
- Response: `inflight` −= 1. If `discard` > 0: word dropped, `discard` −= 1. Else push {`imem_rdata_i`, `rsp_pc`}, `rsp_pc` += 4.
- Grant and response same cycle: `inflight` unchanged.
- Invariant: (inflight − discard) + occ ≤ DEPTH; push never hits a full FIFO. Push and pop same cycle legal at any occupancy, incl. full.
- Jump (`jump_en_i` = 1), priority over all else: `pc` ← `jump_addr_i`, `rsp_pc` ← `jump_addr_i`, FIFO cleared (`occ` ← 0), `discard` ← inflight − `imem_rvalid_i`, `inflight` ← inflight − `imem_rvalid_i`. Response arriving in the jump cycle is dropped. Pop in the jump cycle has no further effect (entry already consumed by decode). No grant possible (req low).
- Back-to-back jumps: each reloads PC; discard recomputed from current inflight.
- Requests may be withdrawn only by a jump; otherwise `imem_addr_o` holds until granted.

## Timing

- Reset values: `pc` = `rsp_pc` = RESET_PC, inflight = discard = occ = 0, `imem_req_o` = 0, `imem_addr_o` = RESET_PC, `inst_valid_o` = 0, `inst_o` = 32'h0000_0013, `inst_addr_o` = 0.
- First `imem_req_o` in the first cycle with `rst` low.
- Latency: grant cycle T, response T+L → `inst_valid_o` at T+L+1 (registered FIFO; no rdata→inst_o combinational path).
- Sustained throughput 1 instr/cycle with L = 1, DEPTH ≥ 2, ready held high.
- Jump in cycle J: new-target request at J+1; FIFO empty (`inst_valid_o` = 0) from J+1.
- Reset mid-operation clears all state in one cycle; responses after reset from pre-reset requests are memory's responsibility (memory reset together).

## Test plan

- Reset release, 1-cycle memory always granting, ready high -> addresses 8000_0000, _0004, _0008… granted back-to-back; `inst_valid_o` first high 2 cycles after first grant, then every cycle with matching `inst_addr_o`.
- Decode stalls (ready low 5 cycles) -> `occ` reaches DEPTH, `imem_req_o` drops, `inst_o`/`inst_addr_o` stable; on release, no word lost or duplicated.
- Jump to 8000_0100 with 2 responses in flight -> both dropped, FIFO empties, next delivered `inst_addr_o` = 8000_0100.
- Jump coinciding with response and with pop -> response dropped, discard = inflight−1, no stale address delivered.
- Random grant/latency (1..4 cycles) and random ready, 10k cycles -> delivered stream equals sequential addresses per jump segment; invariant never violated.
- PC at FFFF_FFFC -> next fetch 0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch unit in front of the decode stage.
//
// Holds the fetch PC and issues in-order word fetches to instruction memory
// over a request/grant + response-valid interface. Returned words go into a
// small FIFO. The head of the FIFO is presented to decode with a valid/ready
// handshake. A jump from execute reloads the PC, empties the FIFO and marks
// every fetch still in flight to be dropped when its response comes back.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   jump_en_i       redirect request from execute (priority over all else)
//   jump_addr_i     redirect target, word aligned
//   imem_req_o      fetch request (held with a stable address until granted)
//   imem_addr_o     fetch address (the current PC)
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   in-order response valid
//   imem_rdata_i    response instruction word
//   inst_valid_o    FIFO head valid
//   inst_o          head instruction, NOP (32'h13) when empty
//   inst_addr_o     head instruction address, 0 when empty
//   inst_ready_i    decode accepts the head
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   addr_q [DEPTH];

  logic          pop;
  logic          grant;
  logic          push;
  logic          drop;
  logic [CW:0]   budget_used;

  assign inst_valid_o = (occ_q != '0);
  assign inst_o       = inst_valid_o ? word_q[rd_ptr_q] : NOP;
  assign inst_addr_o  = inst_valid_o ? addr_q[rd_ptr_q] : 32'h0;
  assign pop          = inst_valid_o & inst_ready_i;

  // Every outstanding fetch (discarded ones included) plus every buffered
  // word reserves one FIFO slot. A pop this cycle frees a slot early, which
  // is what allows one instruction per cycle with DEPTH = 2.
  assign budget_used = {1'b0, inflight_q} + {1'b0, occ_q} - {{CW{1'b0}}, pop};
  assign imem_req_o  = !rst && !jump_en_i && (budget_used < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_q;

  assign grant = imem_req_o & imem_gnt_i;
  assign drop  = (discard_q != '0);
  // Responses in a jump cycle are always dropped, stale or not.
  assign push  = imem_rvalid_i & !drop & !jump_en_i;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (jump_en_i) begin
      pc_d       = jump_addr_i;
      rsp_pc_d   = jump_addr_i;
      occ_d      = '0;
      rd_ptr_d   = wr_ptr_q;
      // Everything still outstanding after this cycle belongs to the old path.
      inflight_d = inflight_q - CW'(imem_rvalid_i);
      discard_d  = inflight_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);
      if (imem_rvalid_i && drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset: occ_q gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      word_q[wr_ptr_q] <= imem_rdata_i;
      addr_q[wr_ptr_q] <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// A behavioural memory (queue of granted fetches with per-fetch latency)
// drives the imem side. The reference model tracks, with plain queues, which
// granted fetches belong to the current jump segment and which addresses sit
// in the buffer, and predicts every DUT output each cycle. A second check
// verifies the popped stream is sequential within each jump segment.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          epoch      = 0;
  int          lat_min    = 1;
  int          lat_max    = 1;
  int          gnt_pct    = 100;
  bit          state_known = 0;
  logic [31:0] fetch_pc   = RESET_PC;
  logic [31:0] exp_seq    = RESET_PC;
  mreq_t       memq[$];
  logic [31:0] mfifo[$];
  logic [31:0] pop_log[$];
  logic [31:0] grant_log[$];
  int          first_grant_cyc = -1;
  int          first_valid_cyc = -1;
  bit          last_req = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step(input bit r, input bit j, input logic [31:0] ja, input bit rdy);
    bit          rv, g, p, exp_v, exp_req;
    logic [31:0] exp_ia, exp_i;
    int          used;
    mreq_t       h;
    @(negedge clk);
    cyc++;
    rst          = r;
    jump_en_i    = j;
    jump_addr_i  = ja;
    inst_ready_i = rdy;
    rv = !r && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word_of(memq[0].addr) : $urandom();
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    #1;
    exp_v   = (mfifo.size() > 0);
    exp_ia  = exp_v ? mfifo[0] : 32'h0;
    exp_i   = exp_v ? word_of(mfifo[0]) : NOP;
    p       = exp_v && rdy;
    used    = memq.size() + mfifo.size() - (p ? 1 : 0);
    exp_req = !r && !j && (used < DEPTH);
    if (state_known) begin
      chk("imem_req",   {31'b0, imem_req_o},   {31'b0, exp_req});
      chk("imem_addr",  imem_addr_o,           fetch_pc);
      chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_v});
      chk("inst",       inst_o,                exp_i);
      chk("inst_addr",  inst_addr_o,           exp_ia);
      if (p && !r) begin
        chk("stream_seq", inst_addr_o, exp_seq);
        exp_seq = exp_seq + 32'd4;
      end
    end
    g = imem_req_o && imem_gnt_i;
    last_req = imem_req_o;
    if (g && first_grant_cyc < 0) first_grant_cyc = cyc;
    if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid_o && rdy && !r) pop_log.push_back(inst_addr_o);
    if (g) grant_log.push_back(imem_addr_o);

    if (r) begin
      memq.delete();
      mfifo.delete();
      fetch_pc = RESET_PC;
      exp_seq  = RESET_PC;
      epoch++;
      state_known = 1;
    end else begin
      if (rv) h = memq.pop_front();
      if (p) void'(mfifo.pop_front());
      if (j) begin
        mfifo.delete();
        epoch++;
        fetch_pc = ja;
        exp_seq  = ja;
      end else begin
        if (rv && h.epoch == epoch) mfifo.push_back(h.addr);
        if (g) begin
          memq.push_back('{addr: imem_addr_o, epoch: epoch,
                           due: cyc + $urandom_range(lat_max, lat_min)});
          fetch_pc = fetch_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    // Reset state.
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    chk("rst_req",       {31'b0, imem_req_o},   32'h0);
    chk("rst_addr",      imem_addr_o,           32'h8000_0000);
    chk("rst_valid",     {31'b0, inst_valid_o}, 32'h0);
    chk("rst_inst",      inst_o,                32'h0000_0013);
    chk("rst_inst_addr", inst_addr_o,           32'h0);

    // Streaming with 1-cycle always-granting memory.
    first_grant_cyc = -1; first_valid_cyc = -1;
    pop_log.delete(); grant_log.delete();
    run(12, 1);
    chk("first_valid_lat", first_valid_cyc - first_grant_cyc, 32'd2);
    chk("grant0", (grant_log.size() > 1) ? grant_log[1] : 32'hDEAD_DEAD, 32'h8000_0004);
    chk("pop0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h8000_0000);
    chk("pop1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_DEAD, 32'h8000_0004);

    // Decode stall: buffer fills, request drops.
    run(5, 0);
    chk("stall_req",   {31'b0, last_req},     32'h0);
    chk("stall_valid", {31'b0, inst_valid_o}, 32'h1);
    run(6, 1);

    // Jump with two fetches in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) step(0, 0, 32'h0, 1);
    step(0, 1, 32'h8000_0100, 1);
    pop_log.delete();
    run(10, 1);
    chk("jump_inflight", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h8000_0100);

    // Jump coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc + 1 && mfifo.size() > 0) break;
      step(0, 0, 32'h0, 1);
    end
    step(0, 1, 32'h8000_0200, 1);
    pop_log.delete();
    run(8, 1);
    chk("jump_rsp_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h8000_0200);

    // Back-to-back jumps: only the last target survives.
    step(0, 1, 32'h8000_0300, 1);
    step(0, 1, 32'h8000_0400, 1);
    pop_log.delete();
    run(8, 1);
    chk("jump_b2b", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h8000_0400);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFF8, 1);
    pop_log.delete(); grant_log.delete();
    run(10, 1);
    idx = -1;
    for (int i = 0; i + 1 < grant_log.size(); i++)
      if (grant_log[i] == 32'hFFFF_FFFC && idx < 0) idx = i;
    chk("wrap_fetch", (idx >= 0) ? grant_log[idx+1] : 32'hDEAD_DEAD, 32'h0000_0000);
    chk("wrap_pop", (pop_log.size() > 2) ? pop_log[2] : 32'hDEAD_DEAD, 32'h0000_0000);

    // Randomised grant, latency, ready, jumps and occasional reset.
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int i = 0; i < 10000; i++) begin
      bit          rr, jj, rd;
      logic [31:0] ja;
      rr = ($urandom_range(999) < 3);
      jj = ($urandom_range(99) < 2);
      rd = ($urandom_range(99) < 70);
      ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(3)), 2'b00})
                                    : {$urandom()} & 32'hFFFF_FFFC;
      step(rr, jj, ja, rd);
    end

    // Reset in the middle of traffic.
    step(1, 0, 32'h0, 1);
    chk("midrst_req",   {31'b0, imem_req_o},   32'h0);
    step(0, 0, 32'h0, 1);
    chk("midrst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("midrst_addr",  imem_addr_o,           32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
